bp_update_scheduler: RTL
========================

// Module: bp_update_scheduler
// PURPOSE
//  Collects resolved-branch predictor updates from the retire lanes, queues them in order,
//  and issues at most one per cycle to the single PHT/BHT write port (wr_en, ex_pc,
//  take_branch, bht_ex_in). Sits between retire and the predictor tables; backpressures retire.
// PARAMETERS
//  LANES   2   retire lanes that can present an update per cycle (>=1)
//  DEPTH   8   queue entries (power of 2, >= LANES)
//  HIST_W  4   local-history index width carried with each update
// PORTS
//  clock         in   1             clock
//  reset         in   1             reset, synchronous, active-high
//  in_valid      in   LANES         lane i carries a resolved conditional branch
//  in_pc         in   LANES*XLEN    branch PC per lane (`XLEN)
//  in_taken      in   LANES         resolved direction per lane
//  in_hist       in   LANES*HIST_W  BHT history used at predict time, per lane
//  in_ready      out  1             all lanes may be accepted this cycle
//  hold          in   1             suppress issue (table maintenance); queue keeps filling
//  clear         in   1             discard every queued update (context switch)
//  upd_wr_en     out  1             issue strobe to PHT/BHT write port
//  upd_pc        out  XLEN          -> ex_pc
//  upd_taken     out  1             -> take_branch
//  upd_hist      out  HIST_W        -> bht_ex_in
//  occupancy     out  $clog2(DEPTH)+1  entries currently queued
// BEHAVIOUR
//  - Reset: queue empty, head/tail/count = 0; in_ready=1, upd_wr_en=0, upd_* = 0, occupancy=0.
//  - in_ready = (DEPTH - count) >= LANES, from registered count only (no dequeue credit same cycle).
//  - Enqueue when in_ready: valid lanes written in lane order (lane 0 oldest), invalid lanes
//    compacted out; tail advances by popcount(in_valid). in_valid while !in_ready is a retire
//    protocol error: lanes are dropped, no state change.
//  - Issue: upd_wr_en = (count!=0) && !hold && !clear; upd_* = head entry (combinational from
//    queue regs); head advances on upd_wr_en. When count==0 or hold, upd_* hold 0.
//  - Latency: update enqueued at edge k is visible on upd_* in cycle k+1 if queue was empty.
//  - Simultaneous enqueue+issue same cycle: count_next = count + popcount - upd_wr_en.
//  - Pointers wrap modulo DEPTH; count never exceeds DEPTH.
//  - clear: count/head/tail -> 0 at next edge; same-cycle in_valid lanes are discarded; no issue.
//  - clear and reset both asserted: reset wins (identical result).
//  - Reset asserted mid-drain: queued updates lost, no upd_wr_en in the reset cycle.
// CONFIGURATION
//  BP_UPDATE_BYPASS_EN defined: when count==0, !hold, !clear and in_ready, the oldest valid
//   lane is driven straight onto upd_* with upd_wr_en=1 in the same cycle and not enqueued;
//   remaining valid lanes enqueue normally. Zero-latency issue.
//  Not defined: every update passes through the queue (one-cycle minimum latency).
// STRUCTURE
//  - bp_pkg: typedef struct packed {logic [`XLEN-1:0] pc; logic taken; logic [HIST_W-1:0] hist;}
//    BP_UPDATE; DEPTH/LANES defaults as localparams.
//  - One sub-module: bp_update_fifo (multi-write, single-read circular buffer of BP_UPDATE,
//    count/head/tail); bp_update_scheduler adds lane compaction, ready, hold/clear, bypass.
// TESTING
//  1. Reset, lane0 {pc=0x100,T,hist=3} -> cycle+1: upd_wr_en=1, upd_pc=0x100, upd_hist=3; occupancy 1->0.
//  2. Both lanes valid every cycle, hold=1 -> occupancy 2,4,6,8; in_ready=0 at 7+ (count>=7);
//     release hold -> 8 issues in lane order, in_ready back to 1 at count<=6.
//  3. in_valid=2'b10 only {pc=0x200} -> stored as single entry, issued next cycle, occupancy 1 peak.
//  4. Wrap: 20 back-to-back single-lane updates, PCs 0x0..0x4C -> issued in exact order, no gaps.
//  5. count=5, clear=1 with both lanes valid -> next cycle occupancy=0, upd_wr_en=0, nothing issued.
//  6. BP_UPDATE_BYPASS_EN, empty queue, lanes {0x300,0x304} -> same cycle upd_pc=0x300 issued,
//     0x304 issued next cycle; without macro 0x300 issued at cycle+1, 0x304 at cycle+2.

Source files
------------

// File: rtl/bp_update_scheduler_pkg.sv
// Shared types for the branch-predictor update scheduler.
// Optional zero-latency path: define BP_UPDATE_BYPASS_EN.
`ifndef XLEN
`define XLEN 32
`endif

package bp_pkg;
  localparam int BP_LANES  = 2;
  localparam int BP_DEPTH  = 8;
  localparam int BP_HIST_W = 4;

  typedef struct packed {
    logic [`XLEN-1:0]     pc;
    logic                 taken;
    logic [BP_HIST_W-1:0] hist;
  } BP_UPDATE;
endpackage

// File: rtl/bp_update_scheduler_if.sv
// Retire-side update lanes and predictor write-port bundle.
// Master drives retire lanes; slave is the scheduler.
interface bp_update_scheduler_if
  import bp_pkg::*;
#(
  parameter int LANES  = BP_LANES,
  parameter int HIST_W = BP_HIST_W
);
  logic [LANES-1:0]        in_valid;
  logic [LANES*`XLEN-1:0]  in_pc;
  logic [LANES-1:0]        in_taken;
  logic [LANES*HIST_W-1:0] in_hist;
  logic                    in_ready;
  logic                    upd_wr_en;
  logic [`XLEN-1:0]        upd_pc;
  logic                    upd_taken;
  logic [HIST_W-1:0]       upd_hist;

  modport master (
    output in_valid, in_pc, in_taken, in_hist,
    input  in_ready,
    input  upd_wr_en, upd_pc, upd_taken, upd_hist
  );

  modport slave (
    input  in_valid, in_pc, in_taken, in_hist,
    output in_ready,
    output upd_wr_en, upd_pc, upd_taken, upd_hist
  );
endinterface

// File: rtl/bp_update_fifo.sv
// Multi-write, single-read circular buffer of predictor updates.
// Writers supply a compacted offset from tail per lane.
module bp_update_fifo
  import bp_pkg::*;
#(
  parameter int LANES = BP_LANES,
  parameter int DEPTH = BP_DEPTH,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clear,
  input  logic [LANES-1:0] wr_en,
  input  logic [AW-1:0]  wr_off [LANES],
  input  logic [CW-1:0]  wr_num,
  input  BP_UPDATE       wr_data [LANES],
  input  logic           rd_en,
  output BP_UPDATE       rd_data,
  output logic [CW-1:0]  count
);
  BP_UPDATE      mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + wr_num[AW-1:0];
      head  <= head + AW'(rd_en);
      count <= count + wr_num - CW'(rd_en);
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i])
        mem[tail + wr_off[i]] <= wr_data[i];
    end
  end

  assign rd_data = mem[head];
endmodule

// File: rtl/bp_update_scheduler.sv
// Queues retire-lane predictor updates and issues one per cycle.
// Build with BP_UPDATE_BYPASS_EN for zero-latency issue when empty.
module bp_update_scheduler
  import bp_pkg::*;
#(
  parameter int LANES  = BP_LANES,
  parameter int DEPTH  = BP_DEPTH,
  parameter int HIST_W = BP_HIST_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   hold,
  input  logic                   clear,
  bp_update_scheduler_if.slave   bus,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]    count;
  BP_UPDATE         lane_d [LANES];
  BP_UPDATE         head_d;
  BP_UPDATE         byp_d;
  BP_UPDATE         out_d;
  logic [LANES-1:0] enq;
  logic [AW-1:0]    off [LANES];
  logic [CW-1:0]    num;
  logic             accept;
  logic             byp_ok;
  logic             byp_take;
  logic             fifo_rd;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_d[i].pc    = bus.in_pc[i*`XLEN +: `XLEN];
      lane_d[i].taken = bus.in_taken[i];
      lane_d[i].hist  = bus.in_hist[i*HIST_W +: HIST_W];
    end
  end

  // Ready uses registered count only; no dequeue credit.
  assign bus.in_ready = (CW'(DEPTH) - count) >= CW'(LANES);
  assign accept  = bus.in_ready && !clear && !reset;
  assign fifo_rd = (count != '0) && !hold && !clear && !reset;

`ifdef BP_UPDATE_BYPASS_EN
  assign byp_ok = (count == '0) && !hold && accept;
`else
  assign byp_ok = 1'b0;
`endif

  // Compact valid lanes; the oldest may skip the queue.
  always_comb begin
    enq      = '0;
    num      = '0;
    byp_take = 1'b0;
    byp_d    = '0;
    for (int i = 0; i < LANES; i++) begin
      off[i] = num[AW-1:0];
      if (bus.in_valid[i] && accept) begin
        if (byp_ok && !byp_take) begin
          byp_take = 1'b1;
          byp_d    = lane_d[i];
        end else begin
          enq[i] = 1'b1;
          num    = num + CW'(1);
        end
      end
    end
  end

  always_comb begin
    out_d = '0;
    if (byp_take)
      out_d = byp_d;
    else if (fifo_rd)
      out_d = head_d;
  end

  assign bus.upd_wr_en = fifo_rd || byp_take;
  assign bus.upd_pc    = out_d.pc;
  assign bus.upd_taken = out_d.taken;
  assign bus.upd_hist  = out_d.hist;
  assign occupancy     = count;

  bp_update_fifo #(
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .wr_en   (enq),
    .wr_off  (off),
    .wr_num  (num),
    .wr_data (lane_d),
    .rd_en   (fifo_rd),
    .rd_data (head_d),
    .count   (count)
  );
endmodule
